// File: rtl/pkt_classifier.sv
// Ingress packet classifier: fall-through input FIFO, header inspection on beats 1-2,
// whole-packet steering to the data or control stream (or drop), per-class packet counters.
module pkt_classifier #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DEPTH_BITS      = 5,
   parameter int NUM_CTRL_PORTS       = 2,
   parameter bit DROP_NON_UDP         = 1'b1
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
   output logic                              ctrl_m_axis_tvalid,
   output logic                              ctrl_m_axis_tlast,
   input  logic                              ctrl_m_axis_tready,
   input  logic [16*NUM_CTRL_PORTS-1:0]      ctrl_port_tbl,
   input  logic [NUM_CTRL_PORTS-1:0]         ctrl_port_en,
   output logic [31:0]                       cnt_data,
   output logic [31:0]                       cnt_ctrl,
   output logic [31:0]                       cnt_drop
);

   localparam int DW    = C_S_AXIS_DATA_WIDTH;
   localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW    = C_S_AXIS_TUSER_WIDTH;
   localparam int AW    = FIFO_DEPTH_BITS;
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   typedef enum logic [2:0] {S_IDLE, S_PEEK, S_SEND_HDR, S_SEND, S_DROP} state_t;

   function automatic logic is_ipv4_udp(input beat_t b);
      return (b.data[143:128] == 16'h0008) && (b.data[223:216] == 8'h11);
   endfunction

   beat_t           mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic            rdy_q;
   beat_t           in_beat, head, hdr_q, out_beat;
   beat_t           m_beat_q, c_beat_q;
   logic            m_vld_q, c_vld_q;
   logic            wr_en, pop, empty, nearly_full;
   state_t          state_q, state_d;
   logic            cls_q, cls_d;
   logic            port_hit, can_load, load, load_hdr, latch_hdr, drop_last;
   logic [31:0]     cnt_data_q, cnt_ctrl_q, cnt_drop_q;

   assign in_beat       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
   assign head          = mem_q[rd_ptr_q];
   assign empty         = (count_q == '0);
   // One slot of margin: ready drops while a single free entry remains.
   assign nearly_full   = (count_q >= (AW+1)'(DEPTH - 1));
   assign s_axis_tready = rdy_q & ~nearly_full;
   assign wr_en         = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= in_beat;
      if (latch_hdr) hdr_q <= head;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
   end

   always_comb begin
      port_hit = 1'b0;
      for (int i = 0; i < NUM_CTRL_PORTS; i++)
         if (ctrl_port_en[i] && (head.data[79:64] == ctrl_port_tbl[16*i +: 16]))
            port_hit = 1'b1;
   end

   // The selected output can take a beat when its register is empty or draining this cycle.
   assign can_load = cls_q ? (~c_vld_q | ctrl_m_axis_tready) : (~m_vld_q | m_axis_tready);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= S_IDLE;
         cls_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      case (state_q)
         S_IDLE: if (!empty) begin
            if (is_ipv4_udp(head)) begin
               cls_d   = 1'b0;
               state_d = head.last ? S_SEND : S_PEEK;
            end else if (DROP_NON_UDP) begin
               state_d = S_DROP;
            end else begin
               cls_d   = 1'b0;
               state_d = S_SEND;
            end
         end
         S_PEEK: if (!empty) begin
            cls_d   = port_hit;
            state_d = S_SEND_HDR;
         end
         S_SEND_HDR: if (can_load) state_d = S_SEND;
         S_SEND:     if (!empty && can_load && head.last) state_d = S_IDLE;
         S_DROP:     if (!empty && head.last) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop       = 1'b0;
      load      = 1'b0;
      load_hdr  = 1'b0;
      latch_hdr = 1'b0;
      drop_last = 1'b0;
      case (state_q)
         S_IDLE: if (!empty && is_ipv4_udp(head) && !head.last) begin
            latch_hdr = 1'b1;
            pop       = 1'b1;
         end
         S_SEND_HDR: if (can_load) begin
            load     = 1'b1;
            load_hdr = 1'b1;
         end
         S_SEND: if (!empty && can_load) begin
            load = 1'b1;
            pop  = 1'b1;
         end
         S_DROP: if (!empty) begin
            pop       = 1'b1;
            drop_last = head.last;
         end
         default: ;
      endcase
   end

   assign out_beat = load_hdr ? hdr_q : head;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         m_vld_q  <= 1'b0;
         m_beat_q <= '0;
         c_vld_q  <= 1'b0;
         c_beat_q <= '0;
      end else begin
         if (load && !cls_q) begin
            m_vld_q  <= 1'b1;
            m_beat_q <= out_beat;
         end else if (m_axis_tready) begin
            m_vld_q  <= 1'b0;
         end
         if (load && cls_q) begin
            c_vld_q  <= 1'b1;
            c_beat_q <= out_beat;
         end else if (ctrl_m_axis_tready) begin
            c_vld_q  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_data_q <= '0;
         cnt_ctrl_q <= '0;
         cnt_drop_q <= '0;
      end else begin
         cnt_data_q <= cnt_data_q + 32'(m_vld_q & m_axis_tready & m_beat_q.last);
         cnt_ctrl_q <= cnt_ctrl_q + 32'(c_vld_q & ctrl_m_axis_tready & c_beat_q.last);
         cnt_drop_q <= cnt_drop_q + 32'(drop_last);
      end
   end

   assign m_axis_tdata       = m_beat_q.data;
   assign m_axis_tkeep       = m_beat_q.keep;
   assign m_axis_tuser       = m_beat_q.user;
   assign m_axis_tlast       = m_beat_q.last;
   assign m_axis_tvalid      = m_vld_q;
   assign ctrl_m_axis_tdata  = c_beat_q.data;
   assign ctrl_m_axis_tkeep  = c_beat_q.keep;
   assign ctrl_m_axis_tuser  = c_beat_q.user;
   assign ctrl_m_axis_tlast  = c_beat_q.last;
   assign ctrl_m_axis_tvalid = c_vld_q;
   assign cnt_data           = cnt_data_q;
   assign cnt_ctrl           = cnt_ctrl_q;
   assign cnt_drop           = cnt_drop_q;

endmodule

// File: tb/tb_pkt_classifier.sv
// Scoreboard bench for pkt_classifier: two builds (DROP_NON_UDP=1 monitored beat by beat,
// DROP_NON_UDP=0 checked through its counters) fed the same directed packets.
module tb_pkt_classifier;

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  k;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   logic [255:0] s_tdata;
   logic [31:0]  s_tkeep;
   logic [127:0] s_tuser;
   logic         s_tvalid, s_tlast, s_tready, s_tready1;
   logic [255:0] m_tdata, c_tdata, m1_tdata, c1_tdata;
   logic [31:0]  m_tkeep, c_tkeep, m1_tkeep, c1_tkeep;
   logic [127:0] m_tuser, c_tuser, m1_tuser, c1_tuser;
   logic         m_tvalid, m_tlast, c_tvalid, c_tlast;
   logic         m1_tvalid, m1_tlast, c1_tvalid, c1_tlast;
   logic         m_tready, c_tready;
   logic [31:0]  tbl;
   logic [1:0]   en;
   logic [31:0]  cnt_d, cnt_c, cnt_x, cnt1_d, cnt1_c, cnt1_x;

   pkt_classifier #(.DROP_NON_UDP(1'b1)) u_dut (
      .clk(clk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .ctrl_m_axis_tdata(c_tdata), .ctrl_m_axis_tkeep(c_tkeep), .ctrl_m_axis_tuser(c_tuser),
      .ctrl_m_axis_tvalid(c_tvalid), .ctrl_m_axis_tlast(c_tlast), .ctrl_m_axis_tready(c_tready),
      .ctrl_port_tbl(tbl), .ctrl_port_en(en),
      .cnt_data(cnt_d), .cnt_ctrl(cnt_c), .cnt_drop(cnt_x)
   );

   pkt_classifier #(.DROP_NON_UDP(1'b0)) u_dut_fwd (
      .clk(clk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready1),
      .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tuser(m1_tuser),
      .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast), .m_axis_tready(1'b1),
      .ctrl_m_axis_tdata(c1_tdata), .ctrl_m_axis_tkeep(c1_tkeep), .ctrl_m_axis_tuser(c1_tuser),
      .ctrl_m_axis_tvalid(c1_tvalid), .ctrl_m_axis_tlast(c1_tlast), .ctrl_m_axis_tready(1'b1),
      .ctrl_port_tbl(tbl), .ctrl_port_en(en),
      .cnt_data(cnt1_d), .cnt_ctrl(cnt1_c), .cnt_drop(cnt1_x)
   );

   int    checks = 0;
   int    errors = 0;
   beat_t q_m[$];
   beat_t q_c[$];
   beat_t cur_m, cur_c, hold_m, hold_c, exp_b;
   logic  held_m = 1'b0, held_c = 1'b0;
   logic  tog = 1'b0;

   assign cur_m = {m_tdata, m_tkeep, m_tuser, m_tlast};
   assign cur_c = {c_tdata, c_tkeep, c_tuser, c_tlast};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                  nm, act.d, act.k, act.u, act.l, exp.d, exp.k, exp.u, exp.l);
      end
   endtask

   // Monitor: handshakes are resolved at the next rising edge, so the falling edge sees them settled.
   always @(negedge clk) begin
      if (!aresetn) begin
         held_m = 1'b0;
         held_c = 1'b0;
      end else begin
         if (held_m && m_tvalid) chk_beat("m_stable", cur_m, hold_m);
         if (held_c && c_tvalid) chk_beat("ctrl_stable", cur_c, hold_c);
         if (m_tvalid && m_tready) begin
            if (q_m.size() == 0) chk("m_unexpected_beat", 32'(m_tlast), 32'hdead);
            else begin
               exp_b = q_m.pop_front();
               chk_beat("m_beat", cur_m, exp_b);
            end
         end
         if (c_tvalid && c_tready) begin
            if (q_c.size() == 0) chk("ctrl_unexpected_beat", 32'(c_tlast), 32'hdead);
            else begin
               exp_b = q_c.pop_front();
               chk_beat("ctrl_beat", cur_c, exp_b);
            end
         end
         held_m = m_tvalid && !m_tready;
         hold_m = cur_m;
         held_c = c_tvalid && !c_tready;
         hold_c = cur_c;
      end
   end

   // dest: 0 expect on data output, 1 expect on control output, 2 expect nothing
   task automatic send_pkt(input int pid, input int nb, input logic [15:0] et, input logic [7:0] pr,
                           input logic [15:0] dp, input int dest, input bit complete);
      beat_t       b;
      logic [31:0] w;
      bit          acc;
      int          n;
      for (int i = 0; i < nb; i++) begin
         w = 32'hA500_0000 + 32'(pid * 256 + i);
         b.d = {8{w}};
         if (i == 0) begin
            b.d[143:128] = et;
            b.d[223:216] = pr;
         end
         b.d[79:64] = dp;
         b.l = complete && (i == nb - 1);
         b.k = b.l ? 32'h0000_ffff : 32'hffff_ffff;
         b.u = {4{~w}};
         if (dest == 0) q_m.push_back(b);
         else if (dest == 1) q_c.push_back(b);
         s_tdata  = b.d;
         s_tkeep  = b.k;
         s_tuser  = b.u;
         s_tlast  = b.l;
         s_tvalid = 1'b1;
         n = 0;
         do begin
            acc = s_tready && s_tready1;
            @(posedge clk);
            #1;
            n++;
         end while (!acc && n < 2000);
         if (!acc) chk("send_timeout", 32'(pid * 256 + i), 32'hffff_ffff);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q_m.size() != 0 || q_c.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", 32'(q_m.size() + q_c.size()), 32'h0);
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
      m_tready = 1'b1; c_tready = 1'b1;
      tbl = {16'h5678, 16'hf2f1};
      en  = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
      chk("rst_ctrl_tvalid", 32'(c_tvalid), 32'h0);
      chk("rst_s_tready", 32'(s_tready), 32'h0);
      chk("rst_m_tdata", m_tdata[31:0], 32'h0);
      chk("rst_cnt_data", cnt_d, 32'h0);
      chk("rst_cnt_ctrl", cnt_c, 32'h0);
      chk("rst_cnt_drop", cnt_x, 32'h0);
      chk("rst_fwd_tvalid", 32'(m1_tvalid | c1_tvalid), 32'h0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      // 3-beat UDP packet to control port in tbl[0]
      send_pkt(1, 3, 16'h0008, 8'h11, 16'hf2f1, 1, 1'b1);
      drain();
      chk("cnt_ctrl_after_ctrl_pkt", cnt_c, 32'd1);

      // 4-beat data packet with toggling data-path ready
      tog = 1'b1;
      fork
         begin
            send_pkt(2, 4, 16'h0008, 8'h11, 16'h1234, 0, 1'b1);
            drain();
            tog = 1'b0;
         end
         begin
            while (tog) begin
               @(posedge clk);
               #1;
               m_tready = ~m_tready;
            end
            m_tready = 1'b1;
         end
      join
      chk("cnt_data_after_toggle_pkt", cnt_d, 32'd1);

      // IPv6 packet: dropped here, forwarded by the DROP_NON_UDP=0 build
      send_pkt(3, 3, 16'hdd86, 8'h11, 16'hf2f1, 2, 1'b1);
      drain();
      chk("cnt_drop_ipv6", cnt_x, 32'd1);

      // tbl[1] match disabled, then enabled
      send_pkt(4, 2, 16'h0008, 8'h11, 16'h5678, 0, 1'b1);
      drain();
      en = 2'b11;
      send_pkt(5, 2, 16'h0008, 8'h11, 16'h5678, 1, 1'b1);
      drain();
      en = 2'b01;

      // single-beat UDP packet goes to data even with a control port in its payload
      send_pkt(6, 1, 16'h0008, 8'h11, 16'hf2f1, 0, 1'b1);
      drain();

      // long control packet with control ready held low for 40 cycles
      c_tready = 1'b0;
      fork
         send_pkt(7, 50, 16'h0008, 8'h11, 16'hf2f1, 1, 1'b1);
         begin
            repeat (40) @(posedge clk);
            #1;
            chk("stall_s_tready", 32'(s_tready), 32'h0);
            chk("stall_ctrl_tvalid", 32'(c_tvalid), 32'h1);
            c_tready = 1'b1;
         end
      join
      drain();

      chk("cnt_data_total", cnt_d, 32'd3);
      chk("cnt_ctrl_total", cnt_c, 32'd3);
      chk("cnt_drop_total", cnt_x, 32'd1);
      chk("fwd_cnt_data_total", cnt1_d, 32'd4);
      chk("fwd_cnt_ctrl_total", cnt1_c, 32'd3);
      chk("fwd_cnt_drop_total", cnt1_x, 32'd0);

      // partial control packet, then reset mid-packet
      c_tready = 1'b0;
      send_pkt(8, 3, 16'h0008, 8'h11, 16'hf2f1, 2, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("partial_ctrl_tvalid", 32'(c_tvalid), 32'h1);
      #2 aresetn = 1'b0;
      #1;
      chk("midrst_ctrl_tvalid", 32'(c_tvalid), 32'h0);
      chk("midrst_m_tvalid", 32'(m_tvalid), 32'h0);
      chk("midrst_ctrl_tdata", c_tdata[31:0], 32'h0);
      chk("midrst_cnt_ctrl", cnt_c, 32'h0);
      chk("midrst_fwd_cnt_data", cnt1_d, 32'h0);
      repeat (2) @(posedge clk);
      #3 aresetn = 1'b1;
      c_tready = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(9, 2, 16'h0008, 8'h11, 16'h1234, 0, 1'b1);
      drain();
      chk("post_rst_cnt_data", cnt_d, 32'd1);
      chk("post_rst_cnt_ctrl", cnt_c, 32'd0);
      chk("post_rst_cnt_drop", cnt_x, 32'd0);
      chk("post_rst_fwd_cnt_data", cnt1_d, 32'd1);
      chk("end_q_m_empty", 32'(q_m.size()), 32'd0);
      chk("end_q_c_empty", 32'(q_c.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
